// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch program-counter unit.
package pc_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int STEP_WORD    = 4;
  localparam int STEP_HALF    = 2;

  typedef enum logic [1:0] {
    UPD_HOLD  = 2'd0,
    UPD_WRITE = 2'd1,
    UPD_JUMP  = 2'd2,
    UPD_TRAP  = 2'd3
  } upd_sel_e;

  // Counter must hold 0..depth inclusive.
  function automatic int ras_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_return_stack.sv
// Circular return-address stack; a push when full silently drops the oldest entry.
module return_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = ras_cnt_width(RAS_DEPTH);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [PTR_W-1:0] w_ptr_up;
  logic [PTR_W-1:0] w_ptr_dn;
  logic             w_is_empty;
  logic             w_is_full;
  logic             w_do_push;
  logic             w_do_replace;
  logic             w_do_pop;

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  always_comb begin
    w_ptr_up     = r_ptr + PTR_W'(1);
    w_ptr_dn     = r_ptr - PTR_W'(1);
    w_is_empty   = (r_cnt == CNT_W'(0));
    w_is_full    = (r_cnt == CNT_W'(RAS_DEPTH));
    w_do_push    = i_push && (!i_pop || w_is_empty);
    w_do_replace = i_push && i_pop && !w_is_empty;
    w_do_pop     = i_pop && !i_push && !w_is_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= {PTR_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= {XLEN{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[w_ptr_up] <= i_push_data;
      r_ptr           <= w_ptr_up;
      if (!w_is_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_do_replace) begin
      r_mem[r_ptr] <= i_push_data;
    end else if (w_do_pop) begin
      r_ptr <= w_ptr_dn;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_empty = w_is_empty;
  assign o_top   = w_is_empty ? {XLEN{1'b0}} : r_mem[r_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/execute/retire program-counter pipeline with trap and jump redirect,
// data-address forwarding and a return-address stack.
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              IALIGN       = 32,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       step_half,
  input  logic                       jump,
  input  logic                       trap,
  input  logic                       pc_relative,
  input  logic                       use_offset,
  input  logic                       forward_address,
  input  logic [XLEN-1:0]            immediate,
  input  logic [XLEN-1:0]            address_in,
  input  logic [XLEN-1:0]            trap_vector,
  input  logic                       ras_push,
  input  logic                       ras_pop,
  output logic [XLEN-1:0]            next,
  output logic [XLEN-1:0]            current,
  output logic [XLEN-1:0]            last,
  output logic [XLEN-1:0]            address_bus,
  output logic [$clog2(XLEN/8)-1:0]  data_offset,
  output logic                       misaligned,
  output logic [XLEN-1:0]            ras_top,
  output logic                       ras_empty
);

  localparam int              OFF_W     = $clog2(XLEN/8);
  localparam logic [XLEN-1:0] TRAP_MASK = ~(XLEN'((IALIGN / 8) - 1));
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'((XLEN / 8) - 1));

  logic [XLEN-1:0]  r_next;
  logic [XLEN-1:0]  r_current;
  logic [XLEN-1:0]  r_last;
  logic [OFF_W-1:0] r_data_offset;
  logic             r_misaligned;

  logic [XLEN-1:0]  w_base;
  logic [XLEN-1:0]  w_sum;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_trap_target;
  logic [XLEN-1:0]  w_step;
  logic [XLEN-1:0]  w_ras_data;
  logic             w_jump_bad;
  upd_sel_e         w_upd;

  // The raw sum stays byte-exact for data forwarding; only the branch target drops bit 0.
  always_comb begin
    w_base        = pc_relative ? r_current : address_in;
    w_sum         = w_base + immediate;
    w_target      = {w_sum[XLEN-1:1], 1'b0};
    w_trap_target = trap_vector & TRAP_MASK;
    w_jump_bad    = (IALIGN == 32) && w_sum[1];
    w_step        = (step_half && (IALIGN == 16)) ? XLEN'(STEP_HALF) : XLEN'(STEP_WORD);
    w_ras_data    = r_current + XLEN'(STEP_WORD);
  end

  always_comb begin
    w_upd = UPD_HOLD;
    if (trap) begin
      w_upd = UPD_TRAP;
    end else if (jump) begin
      w_upd = UPD_JUMP;
    end else if (write) begin
      w_upd = UPD_WRITE;
    end else begin
      w_upd = UPD_HOLD;
    end
  end

  always_comb begin
    address_bus = r_next;
    if (forward_address) begin
      if (use_offset) begin
        address_bus = w_sum;
      end else begin
        address_bus = w_sum & WORD_MASK;
      end
    end else begin
      address_bus = r_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_next       <= RESET_VECTOR;
      r_current    <= RESET_VECTOR;
      r_last       <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= (w_upd == UPD_JUMP) && w_jump_bad;
      case (w_upd)
        UPD_TRAP: r_next <= w_trap_target;
        UPD_JUMP: begin
          if (!w_jump_bad) begin
            r_next <= w_target;
          end
        end
        UPD_WRITE: begin
          r_last    <= r_current;
          r_current <= r_next;
          r_next    <= r_next + w_step;
        end
        default: r_next <= r_next;
      endcase
    end
  end

  // Captured whenever forwarding, regardless of which redirect wins this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_offset <= {OFF_W{1'b0}};
    end else if (forward_address) begin
      r_data_offset <= w_sum[OFF_W-1:0];
    end
  end

  return_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .clock       (clock),
    .reset       (reset),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_push_data (w_ras_data),
    .o_top       (ras_top),
    .o_empty     (ras_empty)
  );

  assign next        = r_next;
  assign current     = r_current;
  assign last        = r_last;
  assign data_offset = r_data_offset;
  assign misaligned  = r_misaligned;

endmodule
